// File: rtl/display_pkg.sv
// Glyph table, digit count and segment bit order shared by the 7-segment
// capture logic and the display driver.
package display_pkg;

  localparam int NUM_DIGITS = 4;

  // Bit position of each segment inside the 7-bit segments bus.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Glyphs written in a..g order, MSB = a.
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // Encoder used on the driver side; returns the glyph in a..g order.
  function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/display_capture_seg_to_hex.sv
// Combinational 7-segment glyph decoder: segments in, hex nibble plus a
// flag saying whether the pattern is one of the 16 legal glyphs.
module seg_to_hex
  import display_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] nibble,
  output logic       glyph_ok
);

  logic [6:0] w_abc;

  // Reorder into a..g so the table below is independent of bus wiring.
  assign w_abc = {segments[SEG_A], segments[SEG_B], segments[SEG_C],
                  segments[SEG_D], segments[SEG_E], segments[SEG_F],
                  segments[SEG_G]};

  always_comb begin
    nibble   = 4'h0;
    glyph_ok = 1'b1;
    case (w_abc)
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Recovers a 4-digit hex value by snooping a multiplexed 7-segment display.
// Define DISPLAY_CAPTURE_ERR_EN to enable the err pulse and err_cnt counter.
module display_capture
  import display_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segments,
  output logic [15:0] data,
  output logic        valid,
  output logic        stale,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    ST_MAX = 8'(SETTLE);
  localparam logic [7:0]    ST_ARM = 8'(SETTLE - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_ARM = TW'(TIMEOUT - 1);

  logic [3:0]    r_an_p0;
  logic [6:0]    r_seg_p0;
  logic [3:0]    r_an_p1;
  logic [6:0]    r_seg_p1;
  logic [7:0]    r_stab;
  logic [3:0]    r_seen;
  logic [15:0]   r_shadow;
  logic [15:0]   r_data;
  logic          r_valid;
  logic          r_stale;
  logic [TW-1:0] r_to;

  logic          w_change;
  logic          w_sample;
  logic          w_onehot;
  logic          w_glyph_ok;
  logic [3:0]    w_nibble;
  logic          w_capture;
  logic [3:0]    w_seen_next;
  logic          w_full;
  logic [15:0]   w_shadow_next;

  // Stage p0: raw display pins registered; p1 holds the previous p0 copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an_p0  <= '0;
      r_seg_p0 <= '0;
      r_an_p1  <= '0;
      r_seg_p1 <= '0;
    end else begin
      r_an_p0  <= anodes;
      r_seg_p0 <= segments;
      r_an_p1  <= r_an_p0;
      r_seg_p1 <= r_seg_p0;
    end
  end

  assign w_change = (r_an_p0 != r_an_p1) || (r_seg_p0 != r_seg_p1);
  // One sample per dwell: only the SETTLE-1 -> SETTLE step fires.
  assign w_sample = !w_change && (r_stab == ST_ARM);
  assign w_onehot = (r_an_p0 != '0) && ((r_an_p0 & (r_an_p0 - 4'd1)) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stab <= '0;
    end else if (w_change) begin
      r_stab <= '0;
    end else if (r_stab != ST_MAX) begin
      r_stab <= r_stab + 8'd1;
    end
  end

  seg_to_hex u_dec (
    .segments (r_seg_p0),
    .nibble   (w_nibble),
    .glyph_ok (w_glyph_ok)
  );

  assign w_capture   = w_sample && w_onehot && w_glyph_ok;
  assign w_seen_next = r_seen | r_an_p0;
  assign w_full      = w_capture && (w_seen_next == 4'hF);

  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_an_p0[i]) w_shadow_next[4*i +: 4] = w_nibble;
    end
  end

  // Stage p2: frame assembly, publish on the fourth distinct digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seen   <= '0;
      r_shadow <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_stale  <= 1'b0;
      r_to     <= '0;
    end else begin
      r_valid <= w_full;
      if (w_capture) begin
        r_shadow <= w_shadow_next;
        r_to     <= '0;
        r_stale  <= 1'b0;
        if (w_full) begin
          r_data <= w_shadow_next;
          r_seen <= '0;
        end else begin
          r_seen <= w_seen_next;
        end
      end else begin
        if (r_to != TO_MAX) r_to <= r_to + 1'b1;
        if (r_to == TO_ARM) begin
          r_seen  <= '0;
          r_stale <= 1'b1;
        end
      end
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign stale = r_stale;

`ifdef DISPLAY_CAPTURE_ERR_EN
  logic       w_illegal;
  logic       r_err;
  logic [7:0] r_err_cnt;

  // Blank (all anodes off) is legal; anything else must be one-hot and a glyph.
  assign w_illegal = w_sample && (r_an_p0 != '0) && !(w_onehot && w_glyph_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_illegal;
      if (w_illegal && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture (SETTLE=4, TIMEOUT=100); error
// expectations follow whether DISPLAY_CAPTURE_ERR_EN is defined.
module tb_display_capture;

`ifdef DISPLAY_CAPTURE_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  // Hand-written glyph table, a..g with a in the MSB.
  localparam logic [6:0] G [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  logic        clk;
  logic        rst_n;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic [15:0] data;
  logic        valid;
  logic        stale;
  logic        err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcount   = 0;
  int vcyc     = 0;
  int ecount   = 0;
  int v0, e0, c0;

  display_capture #(.SETTLE(4), .TIMEOUT(100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .anodes   (anodes),
    .segments (segments),
    .data     (data),
    .valid    (valid),
    .stale    (stale),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and tally the output pulses seen there.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        vcount++;
        vcyc = cyc;
      end
      if (err) ecount++;
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int hold);
    anodes   = an;
    segments = seg;
    step(hold);
  endtask

  initial begin
    rst_n    = 1'b0;
    anodes   = '0;
    segments = '0;
    step(3);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stale", stale, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // Basic frame; valid rises on the 5th edge after the 1000 dwell is
    // registered, i.e. seen on the 6th falling edge after it is driven.
    v0 = vcount;
    dwell(4'b0001, G[1], 10);
    dwell(4'b0010, G[2], 10);
    dwell(4'b0100, G[3], 10);
    c0 = cyc;
    dwell(4'b1000, G[4], 10);
    chk("f1_valid_cnt", vcount - v0, 1);
    chk("f1_data", data, 16'h4321);
    chk("f1_latency", vcyc - c0, 6);
    chk("f1_stale", stale, 0);

    // 3-cycle dwell is too short, so digit 0 is not seen.
    v0 = vcount;
    dwell(4'b0001, G[0], 3);
    dwell(4'b0010, G[5], 10);
    dwell(4'b0100, G[6], 10);
    dwell(4'b1000, G[7], 10);
    chk("short_no_valid", vcount - v0, 0);
    chk("short_data_kept", data, 16'h4321);
    dwell(4'b0001, G[8], 10);
    chk("short_valid", vcount - v0, 1);
    chk("short_data", data, 16'h7658);

    // Minimum dwell of 5: change lands on the sample edge.
    v0 = vcount;
    e0 = ecount;
    dwell(4'b0001, G[11], 5);
    dwell(4'b0010, G[10], 5);
    dwell(4'b0100, G[9], 5);
    dwell(4'b1000, G[8], 5);
    dwell(4'b0000, 7'b1010101, 10);
    chk("min_dwell_valid", vcount - v0, 1);
    chk("min_dwell_data", data, 16'h89AB);
    chk("blank_no_err", ecount - e0, 0);

    // Illegal glyph, then non-one-hot anodes; neither may set seen.
    v0 = vcount;
    e0 = ecount;
    dwell(4'b0100, 7'b1010101, 10);
    chk("bad_glyph_err", ecount - e0, ERR_EN);
    chk("bad_glyph_cnt", err_cnt, ERR_EN);
    dwell(4'b0011, G[5], 10);
    chk("bad_anode_err", ecount - e0, 2 * ERR_EN);
    chk("bad_anode_cnt", err_cnt, 2 * ERR_EN);
    dwell(4'b0100, G[1], 10);
    dwell(4'b1000, G[2], 10);
    chk("bad_no_valid", vcount - v0, 0);
    dwell(4'b0001, G[3], 10);
    dwell(4'b0010, G[4], 10);
    chk("bad_then_valid", vcount - v0, 1);
    chk("bad_then_data", data, 16'h2143);

    // 256 more illegal samples: counter must stop at 255.
    e0 = ecount;
    for (int k = 0; k < 256; k++)
      dwell(4'b0100, k[0] ? 7'b0101010 : 7'b1010101, 6);
    chk("sat_pulses", ecount - e0, 256 * ERR_EN);
    chk("sat_err_cnt", err_cnt, 255 * ERR_EN);

    // Partial frame times out after 100 idle cycles and seen is dropped.
    v0 = vcount;
    dwell(4'b0001, G[9], 10);
    dwell(4'b0010, G[10], 10);
    dwell(4'b0100, G[11], 10);
    chk("to_stale_cleared", stale, 0);
    dwell(4'b0000, 7'b0000000, 90);
    chk("to_not_yet", stale, 0);
    step(15);
    chk("to_stale_set", stale, 1);
    chk("to_no_valid", vcount - v0, 0);
    dwell(4'b1000, G[12], 10);
    chk("to_stale_clr_capture", stale, 0);
    chk("to_seen_dropped", vcount - v0, 0);
    dwell(4'b0001, G[13], 10);
    dwell(4'b0010, G[14], 10);
    dwell(4'b0100, G[15], 10);
    chk("to_valid", vcount - v0, 1);
    chk("to_data", data, 16'hCFED);

    // Reset mid-frame throws away the two captured digits.
    dwell(4'b0001, G[0], 10);
    dwell(4'b0010, G[1], 10);
    dwell(4'b0000, 7'b0000000, 2);
    rst_n = 1'b0;
    step(3);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_stale", stale, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    v0 = vcount;
    dwell(4'b0100, G[5], 10);
    dwell(4'b1000, G[6], 10);
    chk("post_rst_no_valid", vcount - v0, 0);
    // Digits 2,3 are already seen, so the frame completes on digit 1.
    dwell(4'b0001, G[7], 10);
    dwell(4'b0010, G[8], 10);
    dwell(4'b0100, G[9], 10);
    dwell(4'b1000, G[10], 10);
    chk("post_rst_valid", vcount - v0, 1);
    chk("post_rst_data", data, 16'h6587);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_capture.md
DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 Parameter SETTLE, default 4, number of consecutive stable cycles before a digit is sampled (range 1..255).
REQ-002 Parameter TIMEOUT, default 65535, number of cycles without a capture before the partial frame is declared stale.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 anodes  input  4  digit select; one-hot, active-high; bit i selects digit i.
REQ-006 segments  input  7  active-high glyph; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-007 data  output  16  last complete decoded frame; digit i in data[4i+3:4i].
REQ-008 valid  output  1  one-cycle pulse when data is updated.
REQ-009 stale  output  1  level; partial frame timed out, no capture since.
REQ-010 err  output  1  one-cycle pulse on an illegal sample (see REQ-018).
REQ-011 err_cnt  output  8  saturating count of err pulses.

Function
REQ-012 Register anodes and segments once on every clock edge; all decisions use the registered copies.
REQ-013 Stability counter: clear to 0 when either registered input differs from its previous value, else increment, saturating at SETTLE.
REQ-014 Sample event: exactly one per dwell, on the edge where the counter goes from SETTLE-1 to SETTLE; no re-sample until inputs change.
REQ-015 Glyph decode (hex 0..F): 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111; any other pattern is invalid.
REQ-016 Sample with anodes one-hot and a valid glyph: write the nibble to shadow[i], set seen[i]; a repeated digit overwrites its shadow entry.
REQ-017 Sample with anodes == 0000: blanking; no capture, no error.
REQ-018 Sample with anodes nonzero and not one-hot, or with an invalid glyph: no capture, seen unchanged, err pulse.
REQ-019 When a capture makes seen == 1111: data <= shadow including the current nibble on that same edge, valid = 1 for the following cycle only, seen cleared.
REQ-020 Timeout counter clears on every capture, else increments; on reaching TIMEOUT: seen cleared, stale = 1; stale clears on the next capture.
REQ-021 Input change on the same edge as a sample event: the sample uses the stable values; the change restarts the count.
REQ-022 err_cnt saturates at 255.

Reset
REQ-023 While rst_n == 0 at an edge: data = 0, valid = 0, stale = 0, err = 0, err_cnt = 0, seen = 0, shadow = 0, all counters = 0.
REQ-024 Reset mid-frame discards the partial frame; the next frame requires all four digits again.

Configuration
REQ-025 Macro DISPLAY_CAPTURE_ERR_EN defined: REQ-018 err pulse and REQ-011 counter active.
REQ-026 Macro undefined: err and err_cnt tied to 0, port list unchanged, illegal samples silently ignored (no capture).

Structure
REQ-027 Package display_pkg holds the 16 glyph constants, the digit count (4), and the segment bit-order constants, shared with the display driver.
REQ-028 Sub-module seg_to_hex: combinational, segments[6:0] in, nibble[3:0] and glyph_ok out.

Verification
REQ-029 SETTLE=4; drive anodes 0001/0010/0100/1000 with glyphs 1, 2, 3, 4, each held 10 cycles -> one valid pulse, data = 16'h4321, valid 5 cycles after the 1000 dwell starts.
REQ-030 Hold anodes 0001 / segments 1111110 for 3 cycles, then change -> no capture, seen stays 0000.
REQ-031 Segments 1010101 on anodes 0100 -> err pulse, err_cnt = 1, no valid; with macro undefined -> err stays 0.
REQ-032 TIMEOUT=100; capture digits 0..2, then idle 100 cycles -> stale = 1; a full frame then -> stale = 0, valid pulse.
REQ-033 Pull rst_n low after 2 digits are captured, then release and send digits 2, 3 only -> no valid; a full 4-digit frame -> valid.
